// File: rtl/crc_scan_gen.sv
// Raster scan generator: issues output-pixel indices for one frame per start pulse,
// carries sof/eol/eof tags through a pipeline-matched delay line, then flushes and reports done.
module crc_scan_gen #(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] cnt,
  output logic              cnt_vld,
  output logic              busy,
  output logic              done,
  output logic              out_vld,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [7:0]        frame_no
);

  localparam int unsigned XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int unsigned YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int unsigned FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(H_ACT * V_ACT - 1);
  localparam logic [XW-1:0]     X_LAST = XW'(H_ACT - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(V_ACT - 1);
  localparam logic [FW-1:0]     F_INIT = FW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [FW-1:0]   fcnt;
  logic            last_issue;
  logic [3:0]      tag;
  logic [3:0]      dly [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = FLUSH;
      FLUSH:   if (fcnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_vld    = (state == RUN) && pix_en;
    busy       = (state != IDLE);
    done       = (state == DONE);
    last_issue = cnt_vld && (cnt == LAST);
    // Tags are qualified by the issue so idle/held cycles shift zeros into the line.
    tag = {cnt_vld,
           cnt_vld && (x == '0) && (y == '0),
           cnt_vld && (x == X_LAST),
           cnt_vld && (x == X_LAST) && (y == Y_LAST)};
    {out_vld, out_sof, out_eol, out_eof} = dly[PIPE_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      x        <= '0;
      y        <= '0;
      fcnt     <= '0;
      frame_no <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
    end else begin
      // The delay line runs freely: the downstream pipeline never stalls.
      dly[0] <= tag;
      for (int unsigned i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];

      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            x   <= '0;
            y   <= '0;
          end
        end
        RUN: begin
          if (last_issue) begin
            cnt  <= '0;
            x    <= '0;
            y    <= '0;
            fcnt <= F_INIT;
          end else if (cnt_vld) begin
            cnt <= cnt + ADDR_W'(1);
            if (x == X_LAST) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        FLUSH: begin
          if (fcnt != '0) fcnt <= fcnt - FW'(1);
        end
        DONE: begin
          frame_no <= frame_no + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_scan_gen.sv
// Directed bench for crc_scan_gen: 4x3 frame with 4-cycle latency, plus a 1x1 frame with 1-cycle latency.
module tb_crc_scan_gen;

  logic       clk;
  logic       rst, start, pix_en;
  logic [3:0] cnt;
  logic       cnt_vld, busy, done, out_vld, out_sof, out_eol, out_eof;
  logic [7:0] frame_no;

  logic       rst2, start2, pix_en2;
  logic [0:0] cnt2;
  logic       cnt_vld2, busy2, done2, out_vld2, out_sof2, out_eol2, out_eof2;
  logic [7:0] frame_no2;

  int checks   = 0;
  int failures = 0;
  int gap      = 0;
  bit seen     = 0;

  crc_scan_gen #(.H_ACT(4), .V_ACT(3), .ADDR_W(4), .PIPE_LAT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_en(pix_en),
    .cnt(cnt), .cnt_vld(cnt_vld), .busy(busy), .done(done),
    .out_vld(out_vld), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_no(frame_no)
  );

  crc_scan_gen #(.H_ACT(1), .V_ACT(1), .ADDR_W(1), .PIPE_LAT(1)) dut1 (
    .clk(clk), .rst(rst2), .start(start2), .pix_en(pix_en2),
    .cnt(cnt2), .cnt_vld(cnt_vld2), .busy(busy2), .done(done2),
    .out_vld(out_vld2), .out_sof(out_sof2), .out_eol(out_eol2), .out_eof(out_eof2),
    .frame_no(frame_no2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic step(input logic r, input logic s, input logic pe);
    @(posedge clk);
    #1;
    rst = r; start = s; pix_en = pe;
    @(negedge clk);
  endtask

  task automatic track_gap();
    if (cnt_vld) begin
      if (seen && gap != 0) check("t5_gap", gap, 6);
      seen = 1;
      gap  = 0;
    end else begin
      gap++;
    end
  endtask

  initial begin
    int issues, eofs, dones;
    bit got_done;
    rst = 1; start = 0; pix_en = 0;
    rst2 = 1; start2 = 0; pix_en2 = 0;
    repeat (2) step(1, 0, 0);
    rst2 = 0;

    // Reset state
    check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_frame_no", frame_no, 0);
    check("rst2_busy", busy2, 0);

    // Test 1: continuous pix_en
    step(0, 1, 1);
    check("t1_idle_cnt_vld", cnt_vld, 0);
    for (int k = 0; k < 18; k++) begin
      step(0, 0, 1);
      check($sformatf("t1_cnt_%0d", k), cnt, (k < 12) ? k : 0);
      check($sformatf("t1_cnt_vld_%0d", k), cnt_vld, k < 12);
      check($sformatf("t1_out_vld_%0d", k), out_vld, (k >= 4) && (k < 16));
      check($sformatf("t1_sof_%0d", k), out_sof, k == 4);
      check($sformatf("t1_eol_%0d", k), out_eol, (k == 7) || (k == 11) || (k == 15));
      check($sformatf("t1_eof_%0d", k), out_eof, k == 15);
      check($sformatf("t1_done_%0d", k), done, k == 16);
      check($sformatf("t1_busy_%0d", k), busy, k <= 16);
      check($sformatf("t1_frame_no_%0d", k), frame_no, (k == 17) ? 1 : 0);
    end

    // Test 2: pix_en alternating 1,0,1,0...
    step(0, 1, 0);
    issues = 0;
    for (int k = 0; k < 29; k++) begin
      step(0, 0, (k % 2) == 0);
      if (cnt_vld) issues++;
      check($sformatf("t2_cnt_%0d", k), cnt, (k < 23) ? (k + 1) / 2 : 0);
      check($sformatf("t2_cnt_vld_%0d", k), cnt_vld, ((k % 2) == 0) && (k <= 22));
      check($sformatf("t2_out_vld_%0d", k), out_vld, (k >= 4) && (k <= 26) && ((k % 2) == 0));
      check($sformatf("t2_sof_%0d", k), out_sof, k == 4);
      check($sformatf("t2_eol_%0d", k), out_eol, (k == 10) || (k == 18) || (k == 26));
      check($sformatf("t2_eof_%0d", k), out_eof, k == 26);
      check($sformatf("t2_done_%0d", k), done, k == 27);
      check($sformatf("t2_frame_no_%0d", k), frame_no, (k == 28) ? 2 : 1);
    end
    check("t2_issues", issues, 12);

    // Test 3: start during RUN, FLUSH and DONE is ignored
    step(1, 0, 0);
    step(0, 1, 1);
    dones = 0;
    for (int k = 0; k < 21; k++) begin
      step(0, (k == 5) || (k == 13) || (k == 16), 1);
      if (done) dones++;
      if (k == 6)  check("t3_cnt_no_restart", cnt, 6);
      if (k == 14) check("t3_flush_busy", busy, 1);
      if (k == 17) check("t3_busy_after_done", busy, 0);
      if (k == 18) check("t3_still_idle", busy, 0);
    end
    check("t3_done_count", dones, 1);
    check("t3_frame_no", frame_no, 1);

    // Test 4: reset at cnt=5
    step(1, 0, 0);
    step(0, 1, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 1);
    step(1, 0, 1);
    check("t4_cnt_at_rst", cnt, 5);
    for (int k = 6; k < 10; k++) begin
      step(0, 0, 1);
      check($sformatf("t4_busy_%0d", k), busy, 0);
      check($sformatf("t4_cnt_%0d", k), cnt, 0);
      check($sformatf("t4_cnt_vld_%0d", k), cnt_vld, 0);
      check($sformatf("t4_out_vld_%0d", k), out_vld, 0);
    end
    check("t4_frame_no", frame_no, 0);
    step(0, 1, 1);
    issues = 0; eofs = 0; got_done = 0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      step(0, 0, 1);
      if (cnt_vld) issues++;
      if (out_eof) eofs++;
      if (done) got_done = 1;
    end
    check("t4_done_seen", got_done, 1);
    check("t4_issues", issues, 12);
    check("t4_eofs", eofs, 1);

    // Test 5: 256 back-to-back frames
    step(1, 0, 0);
    seen = 0; gap = 0;
    for (int f = 0; f < 256; f++) begin
      step(0, 1, 1);
      check($sformatf("t5_frame_no_%0d", f), frame_no, f);
      track_gap();
      got_done = 0;
      for (int k = 0; k < 40 && !got_done; k++) begin
        step(0, 0, 1);
        track_gap();
        if (done) got_done = 1;
      end
      check($sformatf("t5_done_%0d", f), got_done, 1);
    end
    step(0, 0, 0);
    check("t5_frame_no_wrap", frame_no, 0);
    check("t5_busy_end", busy, 0);

    // Test 6: 1x1 frame, PIPE_LAT=1
    @(posedge clk); #1; start2 = 1; pix_en2 = 1; @(negedge clk);
    check("t6_idle_busy", busy2, 0);
    @(posedge clk); #1; start2 = 0; @(negedge clk);
    check("t6_cnt_vld", cnt_vld2, 1);
    check("t6_cnt", cnt2, 0);
    check("t6_out_vld_early", out_vld2, 0);
    @(posedge clk); #1; @(negedge clk);
    check("t6_out_vld", out_vld2, 1);
    check("t6_sof_eol_eof", {out_sof2, out_eol2, out_eof2}, 3'b111);
    check("t6_cnt_vld_flush", cnt_vld2, 0);
    check("t6_done_early", done2, 0);
    @(posedge clk); #1; @(negedge clk);
    check("t6_done", done2, 1);
    check("t6_out_vld_after", out_vld2, 0);
    @(posedge clk); #1; pix_en2 = 0; @(negedge clk);
    check("t6_frame_no", frame_no2, 1);
    check("t6_busy_end", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
